// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file transfer sequencer: opcodes,
// register function encodings, sequencer states and the S4 scratch index.
package rf_ctrl_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_SWAP = 3'b010;
  localparam logic [2:0] OP_CLR  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_LDI  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  localparam logic [2:0] IDX_S4 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP1 = 2'd1,
    ST_STEP2 = 2'd2,
    ST_STEP3 = 2'd3
  } state_e;

  // SWAP borrows S4 as its temporary, so S4 itself can never be a SWAP operand.
  function automatic logic isIllegal(input logic [2:0] op, input logic [2:0] a,
                                     input logic [2:0] b);
    return (op == OP_ILL) || ((op == OP_SWAP) && ((a == IDX_S4) || (b == IDX_S4)));
  endfunction

endpackage

// File: rtl/rf_enable_decoder.sv
// Turns a register index and write strobe into the active-low one-hot
// RegSel/ScrSel enables; everything stays high when no write is requested.
module rf_enable_decoder
  import rf_ctrl_pkg::*;
(
  input  logic [2:0] wrIdx_i,
  input  logic       wrEn_i,
  output logic [3:0] regSel_o,
  output logic [3:0] scrSel_o
);

  // Index bit 2 picks the scratch bank; within a bank index 0 maps to bit 3.
  always_comb begin
    regSel_o = 4'b1111;
    scrSel_o = 4'b1111;
    if (wrEn_i) begin
      if (wrIdx_i[2]) begin
        scrSel_o[~wrIdx_i[1:0]] = 1'b0;
      end else begin
        regSel_o[~wrIdx_i[1:0]] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rf_transfer_sequencer.sv
// Accepts one transfer command per handshake and steps the register file
// through it, owning every write enable and the I-input mux select.
module rf_transfer_sequencer
  import rf_ctrl_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req,
  input  logic [2:0] Op,
  input  logic [2:0] DstSel,
  input  logic [2:0] SrcSel,
  output logic       Ready,
  output logic       Done,
  output logic       Err,
  output logic [2:0] FunSel,
  output logic [3:0] RegSel,
  output logic [3:0] ScrSel,
  output logic [2:0] OutASel,
  output logic [2:0] OutBSel,
  output logic       ISrcSel
);

  state_e     state_q;
  logic [2:0] opcode_q;
  logic [2:0] dst_q;
  logic [2:0] src_q;
  logic       done_q;
  logic       err_q;

  logic       illegal;
  logic [2:0] wrIdx;
  logic       wrEn;

  assign illegal = isIllegal(opcode_q, dst_q, src_q);

  // Sequencer state plus the latched command; Done/Err pulse for the single
  // cycle following the final step, and a reset simply drops the command.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      opcode_q <= OP_NOP;
      dst_q    <= 3'd0;
      src_q    <= 3'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Req) begin
            opcode_q <= Op;
            dst_q    <= DstSel;
            src_q    <= SrcSel;
            state_q  <= ST_STEP1;
          end
        end
        ST_STEP1: begin
          if ((opcode_q == OP_SWAP) && !illegal) begin
            state_q <= ST_STEP2;
          end else begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            err_q   <= illegal;
          end
        end
        ST_STEP2: begin
          state_q <= ST_STEP3;
        end
        ST_STEP3: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-step decode of the latched command into register-file controls.
  always_comb begin
    FunSel  = FUN_LOAD;
    OutASel = 3'd0;
    ISrcSel = 1'b0;
    wrIdx   = 3'd0;
    wrEn    = 1'b0;
    case (state_q)
      ST_STEP1: begin
        case (opcode_q)
          OP_MOV: begin
            OutASel = src_q;
            ISrcSel = 1'b1;
            wrIdx   = dst_q;
            wrEn    = 1'b1;
          end
          OP_SWAP: begin
            if (!illegal) begin
              OutASel = dst_q;
              ISrcSel = 1'b1;
              wrIdx   = IDX_S4;
              wrEn    = 1'b1;
            end
          end
          OP_CLR: begin
            FunSel = FUN_CLR;
            wrIdx  = dst_q;
            wrEn   = 1'b1;
          end
          OP_INC: begin
            FunSel = FUN_INC;
            wrIdx  = dst_q;
            wrEn   = 1'b1;
          end
          OP_DEC: begin
            FunSel = FUN_DEC;
            wrIdx  = dst_q;
            wrEn   = 1'b1;
          end
          OP_LDI: begin
            wrIdx = dst_q;
            wrEn  = 1'b1;
          end
          default: begin
            wrEn = 1'b0;
          end
        endcase
      end
      ST_STEP2: begin
        OutASel = src_q;
        ISrcSel = 1'b1;
        wrIdx   = dst_q;
        wrEn    = 1'b1;
      end
      ST_STEP3: begin
        OutASel = IDX_S4;
        ISrcSel = 1'b1;
        wrIdx   = src_q;
        wrEn    = 1'b1;
      end
      default: begin
        wrEn = 1'b0;
      end
    endcase
  end

  rf_enable_decoder u_enableDecoder (
    .wrIdx_i  (wrIdx),
    .wrEn_i   (wrEn),
    .regSel_o (RegSel),
    .scrSel_o (ScrSel)
  );

  assign Ready   = (state_q == ST_IDLE);
  assign Done    = done_q;
  assign Err     = err_q;
  assign OutBSel = (state_q == ST_IDLE) ? 3'd0 : src_q;

endmodule

// File: tb/tb_rf_transfer_sequencer.sv
// Directed bench: a behavioural register file follows the sequencer's
// controls and register contents are compared against hand-computed values.
module tb_rf_transfer_sequencer;
  import rf_ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Req;
  logic [2:0]  Op;
  logic [2:0]  DstSel;
  logic [2:0]  SrcSel;
  logic        Ready;
  logic        Done;
  logic        Err;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic        ISrcSel;

  logic [15:0] extData;
  logic [15:0] rfModel [8];
  logic [15:0] rfIn;
  logic [7:0]  enN;
  logic [15:0] snap [8];

  int checkCount = 0;
  int errorCount = 0;
  int lastLatency;
  int lastBusy;
  int lastWrites;
  logic lastErr;
  logic [2:0] lastOutB;

  always #5 Clock = ~Clock;

  rf_transfer_sequencer dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Req     (Req),
    .Op      (Op),
    .DstSel  (DstSel),
    .SrcSel  (SrcSel),
    .Ready   (Ready),
    .Done    (Done),
    .Err     (Err),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .ISrcSel (ISrcSel)
  );

  // Register file model: index i (R1..R4, S1..S4) is enabled by enN[7-i].
  assign enN  = {RegSel, ScrSel};
  assign rfIn = ISrcSel ? rfModel[OutASel] : extData;

  always @(posedge Clock) begin
    for (int i = 0; i < 8; i++) begin
      if (!enN[7-i]) begin
        case (FunSel)
          3'b000:  rfModel[i] <= rfModel[i] - 16'd1;
          3'b001:  rfModel[i] <= rfModel[i] + 16'd1;
          3'b010:  rfModel[i] <= rfIn;
          3'b011:  rfModel[i] <= 16'd0;
          default: rfModel[i] <= rfModel[i];
        endcase
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // At most one enable may be low at any time.
  always @(negedge Clock) begin
    if (!Reset) checkOutput("oneHot", 32'($countones(enN) >= 7), 32'd1);
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] dst,
                               input logic [2:0] src);
    bit gotDone;
    int waitCycles;
    waitCycles = 0;
    @(negedge Clock);
    while (!Ready && waitCycles < 20) begin
      @(negedge Clock);
      waitCycles++;
    end
    if (!Ready) checkOutput("readyTimeout", 32'(Ready), 32'd1);
    Req = 1'b1; Op = op; DstSel = dst; SrcSel = src;
    @(posedge Clock);
    #1 Req = 1'b0;
    gotDone = 0; lastLatency = 0; lastBusy = 0; lastWrites = 0; lastErr = 1'b0;
    lastOutB = 3'd0;
    for (int n = 1; n <= 10 && !gotDone; n++) begin
      @(negedge Clock);
      if (n == 1) lastOutB = OutBSel;
      if (!Ready) lastBusy++;
      lastWrites += 8 - $countones(enN);
      if (Done) begin
        gotDone = 1;
        lastLatency = n;
        lastErr = Err;
      end
    end
    if (!gotDone) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic loadReg(input logic [2:0] idx, input logic [15:0] val);
    extData = val;
    applyStimulus(OP_LDI, idx, 3'd0);
  endtask

  initial begin
    bit doneSeen;
    Reset = 1'b1; Req = 1'b0; Op = 3'd0; DstSel = 3'd0; SrcSel = 3'd0; extData = 16'd0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("rstReady", 32'(Ready), 32'd1);
    checkOutput("rstRegSel", 32'(RegSel), 32'hF);
    checkOutput("rstScrSel", 32'(ScrSel), 32'hF);
    checkOutput("rstDone", 32'(Done), 32'd0);
    checkOutput("rstErr", 32'(Err), 32'd0);
    checkOutput("rstFunSel", 32'(FunSel), 32'h2);
    checkOutput("rstOutB", 32'(OutBSel), 32'd0);

    loadReg(3'd1, 16'h1234);
    checkOutput("ldiR2", 32'(rfModel[1]), 32'h1234);
    checkOutput("ldiLatency", 32'(lastLatency), 32'd2);

    applyStimulus(OP_MOV, 3'd0, 3'd1);
    checkOutput("movR1", 32'(rfModel[0]), 32'h1234);
    checkOutput("movLatency", 32'(lastLatency), 32'd2);
    checkOutput("movErr", 32'(lastErr), 32'd0);
    checkOutput("movWrites", 32'(lastWrites), 32'd1);
    checkOutput("movOutB", 32'(lastOutB), 32'd1);

    loadReg(3'd0, 16'hAAAA);
    loadReg(3'd2, 16'h5555);
    applyStimulus(OP_SWAP, 3'd0, 3'd2);
    checkOutput("swapR1", 32'(rfModel[0]), 32'h5555);
    checkOutput("swapR3", 32'(rfModel[2]), 32'hAAAA);
    checkOutput("swapS4", 32'(rfModel[7]), 32'hAAAA);
    checkOutput("swapLatency", 32'(lastLatency), 32'd4);
    checkOutput("swapBusy", 32'(lastBusy), 32'd3);
    checkOutput("swapWrites", 32'(lastWrites), 32'd3);
    checkOutput("swapErr", 32'(lastErr), 32'd0);

    loadReg(3'd3, 16'hFFFF);
    applyStimulus(OP_INC, 3'd3, 3'd0);
    checkOutput("incWrap", 32'(rfModel[3]), 32'h0000);
    applyStimulus(OP_DEC, 3'd3, 3'd0);
    checkOutput("decWrap", 32'(rfModel[3]), 32'hFFFF);

    for (int i = 0; i < 8; i++) snap[i] = rfModel[i];
    applyStimulus(OP_ILL, 3'd1, 3'd2);
    checkOutput("illErr", 32'(lastErr), 32'd1);
    checkOutput("illLatency", 32'(lastLatency), 32'd2);
    checkOutput("illWrites", 32'(lastWrites), 32'd0);
    applyStimulus(OP_SWAP, 3'd0, 3'd7);
    checkOutput("swapS4Err", 32'(lastErr), 32'd1);
    checkOutput("swapS4Latency", 32'(lastLatency), 32'd2);
    checkOutput("swapS4Writes", 32'(lastWrites), 32'd0);
    applyStimulus(OP_NOP, 3'd2, 3'd3);
    checkOutput("nopErr", 32'(lastErr), 32'd0);
    checkOutput("nopWrites", 32'(lastWrites), 32'd0);
    for (int i = 0; i < 8; i++) checkOutput("illUnchanged", 32'(rfModel[i]), 32'(snap[i]));

    applyStimulus(OP_CLR, 3'd1, 3'd0);
    checkOutput("clrR2", 32'(rfModel[1]), 32'h0000);

    // Abort a SWAP during its second step.
    loadReg(3'd0, 16'h1111);
    loadReg(3'd1, 16'h2222);
    @(negedge Clock);
    Req = 1'b1; Op = OP_SWAP; DstSel = 3'd0; SrcSel = 3'd1;
    @(posedge Clock);
    #1 Req = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("abortInStep2", 32'(RegSel), 32'h7);
    Reset = 1'b1;
    #1;
    checkOutput("abortRegSel", 32'(RegSel), 32'hF);
    checkOutput("abortScrSel", 32'(ScrSel), 32'hF);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    doneSeen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge Clock);
      if (Done) doneSeen = 1;
    end
    checkOutput("abortNoDone", 32'(doneSeen), 32'd0);
    checkOutput("abortReady", 32'(Ready), 32'd1);
    checkOutput("abortS4", 32'(rfModel[7]), 32'h1111);
    checkOutput("abortR1", 32'(rfModel[0]), 32'h1111);
    checkOutput("abortR2", 32'(rfModel[1]), 32'h2222);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rf_transfer_sequencer.md
# rf_transfer_sequencer

Multi-cycle controller that drives the register file's write/read control inputs: `FunSel`, `RegSel`, `ScrSel`, `OutASel` and `OutBSel`. It also drives the select of the mux feeding the register file's `I` input. A requester issues one transfer command per valid/ready handshake. The block sequences the command into one or three register-file cycles and reports completion. It sits between the instruction control unit and the register file, and owns every write-enable into the file.

## Interface
Parameters: none. Register index encoding is fixed:
- 0–3 select R1–R4.
- 4–7 select S1–S4.

Ports. Clock and reset: one clock; reset is asynchronous and active-high.
- `Clock`  in  1  single clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Req`  in  1  command valid.
- `Op`  in  3  command opcode; see Operation.
- `DstSel`  in  3  destination register index (operand A for SWAP).
- `SrcSel`  in  3  source register index (operand B for SWAP).
- `Ready`  out  1  block can accept a command this cycle.
- `Done`  out  1  one-cycle pulse after a command completes.
- `Err`  out  1  valid only with `Done`; the completed command was illegal and no write occurred.
- `FunSel`  out  3  register function: 000 dec, 001 inc, 010 load, 011 clear.
- `RegSel`  out  4  active-low enables: bit3=R1 … bit0=R4.
- `ScrSel`  out  4  active-low enables: bit3=S1 … bit0=S4.
- `OutASel`  out  3  OutA read index.
- `OutBSel`  out  3  OutB read index.
- `ISrcSel`  out  1  `I` mux select: 0 = external data, 1 = OutA loopback.

## Operation
- Command is accepted on a rising edge where `Req && Ready`. `Op`, `DstSel` and `SrcSel` are latched at that edge.
- Opcodes:
  - 000 NOP: no write.
  - 001 MOV: `Dst <= Src`.
  - 010 SWAP: exchange `Dst` and `Src`, using S4 as temporary.
  - 011 CLR: `Dst <= 0`.
  - 100 INC: `Dst <= Dst + 1`.
  - 101 DEC: `Dst <= Dst - 1`.
  - 110 LDI: `Dst <=` external data.
  - 111: illegal.
- FSM states: IDLE, STEP1, STEP2, STEP3.
  - Accept moves IDLE → STEP1.
  - Every opcode except SWAP returns STEP1 → IDLE.
  - SWAP runs STEP1 → STEP2 → STEP3 → IDLE.
- Step control (write occurs on the edge ending the step):
  - MOV STEP1: `OutASel`=Src, `ISrcSel`=1, `FunSel`=010, enable Dst.
  - CLR, INC, DEC STEP1: `FunSel`=011, 001 or 000 respectively; enable Dst.
  - LDI STEP1: `ISrcSel`=0, `FunSel`=010, enable Dst.
  - SWAP STEP1: `OutASel`=A, `ISrcSel`=1, `FunSel`=010, enable S4 (`ScrSel`=1110).
  - SWAP STEP2: `OutASel`=B, write A.
  - SWAP STEP3: `OutASel`=7, write B.
- Exactly one enable bit across `RegSel`/`ScrSel` is low during a write step. All enable bits are high otherwise.
- `OutBSel` equals the latched `SrcSel` while busy and 0 in IDLE.
- Illegal commands run a single STEP1 with no enable and complete with `Err`=1:
  - opcode 111;
  - SWAP with either operand = 7.
- NOP runs a single STEP1 with no enable; `Err`=0.
- SWAP with A==B executes all three steps normally.

## Timing
- Reset values:
  - state IDLE;
  - `Ready`=1, `Done`=0, `Err`=0;
  - `RegSel`=1111, `ScrSel`=1111;
  - `FunSel`=010;
  - `OutASel`=0, `OutBSel`=0, `ISrcSel`=0.
- Control outputs are a combinational decode of the state and the latched command. Enables go high asynchronously when `Reset` rises.
- Latency from accept edge to completion:
  - single-step commands: `Done` high 2 cycles after the accept edge (1 write step, then `Done`);
  - SWAP: `Done` high 4 cycles after the accept edge.
- `Done` and `Err` are registered and high for exactly the one cycle after the final step's edge. The state is IDLE in that cycle.
- `Ready`=1 only in IDLE. A new command may be accepted in the same cycle `Done` is high (back-to-back).
- `Req` while busy is ignored; it must be held until `Ready`.
- Reset mid-SWAP aborts the command:
  - writes already committed remain;
  - no `Done` pulse is produced.

## Structure
- Shared package `rf_ctrl_pkg`:
  - opcode constants;
  - FunSel encodings (DEC, INC, LOAD, CLR);
  - state enum;
  - index constant `IDX_S4`=7.
- Sub-module `rf_enable_decoder`: maps a 3-bit index plus a write strobe to `RegSel`/`ScrSel` (active-low one-hot, all ones when the strobe is low). It is instantiated once.

## Test plan
Bench: drive a register-file model with `Clock`, load initial values, and issue commands.
- Reset, then idle: `Ready`=1, `RegSel`=`ScrSel`=1111, `Done`=0.
- R2=0x1234; MOV Dst=0, Src=1 → R1=0x1234 at the step edge; `Done` 2 cycles after accept; `Err`=0.
- R1=0xAAAA, R3=0x5555; SWAP A=0, B=2:
  - R1=0x5555, R3=0xAAAA, S4=0xAAAA;
  - `Ready` low for 3 cycles.
- R4=0xFFFF; INC Dst=3 → R4=0x0000 (wrap). Then DEC → 0xFFFF.
- Illegal inputs:
  - Op=111 → `Done`=`Err`=1, no enable asserted, all registers unchanged;
  - SWAP with B=7 → same result.
- Abort: assert `Reset` during SWAP STEP2 → enables high immediately, S4 holds the copy of A, no `Done`, `Ready`=1 after release.
